// File: rtl/mdio_pkg.sv
// Shared constants, FSM state type and frame builder for the Clause-22 MDIO master.
package mdio_pkg;

  localparam logic [1:0] MDIO_ST       = 2'b01;
  localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
  localparam logic [1:0] MDIO_OP_READ  = 2'b10;
  localparam logic [1:0] MDIO_TA_WRITE = 2'b10;

  localparam int unsigned MDIO_FRAME_BITS    = 64;
  localparam int unsigned MDIO_PREAMBLE_BITS = 32;
  localparam int unsigned MDIO_DATA_START    = 48;

  typedef enum logic [2:0] {
    PHY_RST,
    PHY_WAIT,
    IDLE,
    SHIFT,
    DONE
  } mdio_state_t;

  // Read frames carry ones in the TA/data slots; those bits are released on the wire anyway.
  function automatic logic [63:0] mdio_build_frame(
    input logic        read,
    input logic [4:0]  phy_addr,
    input logic [4:0]  reg_addr,
    input logic [15:0] wdata
  );
    mdio_build_frame = {{MDIO_PREAMBLE_BITS{1'b1}}, MDIO_ST,
                        read ? MDIO_OP_READ : MDIO_OP_WRITE,
                        phy_addr, reg_addr,
                        read ? 2'b11 : MDIO_TA_WRITE,
                        read ? 16'hFFFF : wdata};
  endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: one bit period is CLK_DIV low cycles then CLK_DIV high cycles, strobes lead the pin by one cycle.
module mdio_clk_gen
  import mdio_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic mdc,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int unsigned PERIOD = 2 * CLK_DIV;
  localparam int unsigned CW     = $clog2(PERIOD);

  logic [CW-1:0] cnt;

  assign fall_stb = en && (cnt == '0);
  assign rise_stb = en && (cnt == CW'(CLK_DIV));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else begin
      cnt <= (cnt == CW'(PERIOD - 1)) ? '0 : cnt + CW'(1);
      if (fall_stb)
        mdc <= 1'b0;
      else if (rise_stb)
        mdc <= 1'b1;
    end
  end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO management master with PHY reset sequencing and a valid/ready command port.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int unsigned CLK_DIV         = 50,
  parameter int unsigned PHY_RST_CYCLES  = 2000000,
  parameter int unsigned PHY_WAIT_CYCLES = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_read,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_error,
  output logic        eth_mdc,
  output logic        eth_mdio_o,
  output logic        eth_mdio_t,
  input  logic        eth_mdio_i,
  output logic        eth_reset_n
);

  localparam logic [6:0] TA_START   = 7'(MDIO_DATA_START - 2);
  localparam logic [6:0] TA_ACK_CNT = 7'(MDIO_DATA_START);
  localparam logic [6:0] LAST_CNT   = 7'(MDIO_FRAME_BITS);

  mdio_state_t state, state_next;

  logic [31:0] cnt;
  logic [63:0] frame;
  logic        is_read;
  logic [6:0]  bit_cnt;
  logic [15:0] rd_shift;
  logic        ta_bad;
  logic        fall_stb, rise_stb;
  logic        frame_end;

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clock    (clock),
    .reset    (reset),
    .en       (state == SHIFT),
    .mdc      (eth_mdc),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  // bit_cnt counts bits already launched, so the fall after bit 63 sees all 64.
  assign frame_end = fall_stb && (bit_cnt == LAST_CNT);

  always_comb begin
    state_next = state;
    case (state)
      PHY_RST:  if (cnt == 32'(PHY_RST_CYCLES - 1))  state_next = PHY_WAIT;
      PHY_WAIT: if (cnt == 32'(PHY_WAIT_CYCLES - 1)) state_next = IDLE;
      IDLE:     if (cmd_valid)                        state_next = SHIFT;
      SHIFT:    if (frame_end)                        state_next = DONE;
      DONE:                                           state_next = IDLE;
      default:                                        state_next = PHY_RST;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= PHY_RST;
      cnt         <= '0;
      eth_reset_n <= 1'b0;
      eth_mdio_o  <= 1'b1;
      eth_mdio_t  <= 1'b1;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      frame       <= '0;
      is_read     <= 1'b0;
      bit_cnt     <= '0;
      rd_shift    <= '0;
      ta_bad      <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= ((state == PHY_RST || state == PHY_WAIT) && state_next == state) ? cnt + 32'd1 : '0;
      if (state == PHY_RST && state_next == PHY_WAIT)
        eth_reset_n <= 1'b1;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            frame   <= mdio_build_frame(cmd_read, cmd_phy_addr, cmd_reg_addr, cmd_wdata);
            is_read <= cmd_read;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (frame_end) begin
            eth_mdio_o <= 1'b1;
            eth_mdio_t <= 1'b1;
            if (is_read) begin
              rsp_rdata <= rd_shift;
              rsp_error <= ta_bad;
            end else begin
              rsp_error <= 1'b0;
            end
          end else if (fall_stb) begin
            eth_mdio_o <= frame[63];
            eth_mdio_t <= is_read && (bit_cnt >= TA_START);
            frame      <= {frame[62:0], 1'b1};
            bit_cnt    <= bit_cnt + 7'd1;
          end
          if (rise_stb) begin
            if (bit_cnt == TA_ACK_CNT)
              ta_bad <= eth_mdio_i;
            if (bit_cnt > TA_ACK_CNT)
              rd_shift <= {rd_shift[14:0], eth_mdio_i};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Directed plus randomized bench for mdio_master with a bit-level PHY model driven from MDC.
module tb_mdio_master;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_read = 1'b0;
  logic [4:0]  cmd_phy_addr = '0;
  logic [4:0]  cmd_reg_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_error;
  logic        eth_mdc;
  logic        eth_mdio_o;
  logic        eth_mdio_t;
  logic        eth_mdio_i = 1'b1;
  logic        eth_reset_n;

  int          n_cmp = 0;
  int          n_err = 0;
  int          rise_n = 0;
  int          base = 0;
  bit          phy_present = 1'b0;
  logic [15:0] phy_data = '0;
  logic [63:0] cap_o = '0;
  logic [63:0] cap_t = '0;
  logic [15:0] last_rdata = '0;

  mdio_master #(.CLK_DIV(4), .PHY_RST_CYCLES(16), .PHY_WAIT_CYCLES(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_read     (cmd_read),
    .cmd_phy_addr (cmd_phy_addr),
    .cmd_reg_addr (cmd_reg_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .eth_mdc      (eth_mdc),
    .eth_mdio_o   (eth_mdio_o),
    .eth_mdio_t   (eth_mdio_t),
    .eth_mdio_i   (eth_mdio_i),
    .eth_reset_n  (eth_reset_n)
  );

  always #5 clock = ~clock;

  // PHY model: capture the wire at each MDC rise, then present the next bit shortly after.
  always @(posedge eth_mdc) begin
    int j;
    j = rise_n - base;
    if (j >= 0 && j < 64) begin
      cap_o[63 - j] = eth_mdio_o;
      cap_t[63 - j] = eth_mdio_t;
    end
    rise_n = rise_n + 1;
    #1;
    j = j + 1;
    if (phy_present && j == 47)
      eth_mdio_i = 1'b0;
    else if (phy_present && j >= 48 && j <= 63)
      eth_mdio_i = phy_data[63 - j];
    else
      eth_mdio_i = 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic boot_check(input bit poke);
    int t_rstn = -1;
    int t_rdy  = -1;
    int r0;
    bit saw_rsp = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    r0 = rise_n;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (poke && k == 10) begin
        cmd_valid = 1'b1; cmd_read = 1'b0; cmd_phy_addr = 5'h07; cmd_reg_addr = 5'h00; cmd_wdata = 16'hA5A5;
      end
      if (poke && k == 11) cmd_valid = 1'b0;
      if (eth_reset_n && t_rstn < 0) t_rstn = k;
      if (cmd_ready && t_rdy < 0) t_rdy = k;
      if (rsp_valid) saw_rsp = 1'b1;
    end
    chk("boot_reset_n_rise", 64'(t_rstn), 64'd16);
    chk("boot_cmd_ready_rise", 64'(t_rdy), 64'd24);
    chk("boot_no_mdc", 64'(rise_n - r0), 64'd0);
    chk("boot_no_rsp", 64'(saw_rsp), 64'd0);
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    while (!cmd_ready && w < 50) begin
      @(posedge clock); #1;
      w++;
    end
    chk(tag, 64'(w < 50), 64'd1);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    for (int i = 1; i <= 700; i++) begin
      @(posedge clock); #1;
      if (rsp_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_cmd(input bit rd, input logic [4:0] pa, input logic [4:0] ra,
                         input logic [15:0] wd, input bit present, input logic [15:0] pdata);
    logic [63:0] exp_frame;
    logic [63:0] exp_t;
    logic [15:0] exp_rdata;
    bit          exp_err;
    int          n;
    exp_frame = {32'hFFFF_FFFF, 2'b01, (rd ? 2'b10 : 2'b01), pa, ra, 2'b10, wd};
    exp_t     = rd ? 64'h0000_0000_0003_FFFF : 64'h0;
    exp_err   = rd && !present;
    exp_rdata = !rd ? last_rdata : (present ? pdata : 16'hFFFF);

    phy_present = present;
    phy_data    = pdata;
    cmd_read = rd; cmd_phy_addr = pa; cmd_reg_addr = ra; cmd_wdata = wd;
    cmd_valid = 1'b1;
    wait_ready("cmd_ready_timeout");
    base = rise_n;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    wait_rsp(n);
    chk("rsp_latency", 64'(n), 64'd513);
    chk("rsp_error", 64'(rsp_error), 64'(exp_err));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
    chk("mdc_rises", 64'(rise_n - base), 64'd64);
    if (rd)
      chk("frame_bits_read", 64'(cap_o[63:18]), 64'(exp_frame[63:18]));
    else
      chk("frame_bits_write", cap_o, exp_frame);
    chk("tristate_bits", cap_t, exp_t);
    last_rdata = exp_rdata;
    @(posedge clock); #1;
    chk("rsp_pulse_then_ready", 64'({rsp_valid, cmd_ready}), 64'b01);
  endtask

  initial begin
    int n;
    int acc;
    bit prev;
    bit hold;
    logic [15:0] d1, d2;

    #2 reset = 1'b0;
    #1;
    chk("reset_outputs", 64'({eth_reset_n, cmd_ready, rsp_valid, rsp_error, eth_mdc, eth_mdio_o, eth_mdio_t}), 64'b0000011);
    chk("reset_rdata", 64'(rsp_rdata), 64'd0);

    boot_check(1'b1);

    run_cmd(1'b0, 5'h07, 5'h00, 16'h1140, 1'b0, 16'h0000);
    run_cmd(1'b1, 5'h07, 5'h02, 16'h0000, 1'b1, 16'h0141);
    run_cmd(1'b1, 5'h07, 5'h02, 16'h0000, 1'b0, 16'h0000);

    for (int i = 0; i < 6; i++)
      run_cmd(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 1'($urandom), 16'($urandom));

    // Back-to-back reads with cmd_valid held high.
    d1 = 16'($urandom);
    d2 = ~d1;
    phy_present = 1'b1;
    phy_data = d1;
    cmd_read = 1'b1; cmd_phy_addr = 5'h07; cmd_reg_addr = 5'h02;
    cmd_valid = 1'b1;
    wait_ready("b2b_ready_timeout");
    base = rise_n;
    @(posedge clock); #1;
    cmd_reg_addr = 5'h03;
    wait_rsp(n);
    chk("b2b_first_latency", 64'(n), 64'd513);
    chk("b2b_first_rdata", 64'(rsp_rdata), 64'(d1));
    phy_data = d2;
    prev = cmd_ready;
    acc = -1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clock); #1;
      if (prev) begin
        acc = e;
        break;
      end
      prev = cmd_ready;
    end
    chk("b2b_accept_gap", 64'(acc), 64'd2);
    cmd_valid = 1'b0;
    base = rise_n;
    hold = 1'b1;
    n = 0;
    for (int i = 1; i <= 700; i++) begin
      @(posedge clock); #1;
      if (rsp_valid) begin
        n = i;
        break;
      end
      if (rsp_rdata !== d1) hold = 1'b0;
    end
    chk("b2b_rdata_hold", 64'(hold), 64'd1);
    chk("b2b_second_latency", 64'(n), 64'd513);
    chk("b2b_second_rdata", 64'(rsp_rdata), 64'(d2));
    chk("b2b_second_error", 64'(rsp_error), 64'd0);
    last_rdata = d2;

    // Reset asserted during bit 40 of a write.
    phy_present = 1'b0;
    cmd_read = 1'b0; cmd_phy_addr = 5'h01; cmd_reg_addr = 5'h04; cmd_wdata = 16'hBEEF;
    cmd_valid = 1'b1;
    wait_ready("midrst_ready_timeout");
    base = rise_n;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    acc = 0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clock); #1;
      if (rise_n - base >= 41) begin
        acc = 1;
        break;
      end
    end
    chk("midrst_reached_bit40", 64'(acc), 64'd1);
    reset = 1'b0;
    #1;
    chk("midrst_outputs", 64'({eth_reset_n, cmd_ready, rsp_valid, rsp_error, eth_mdc, eth_mdio_o, eth_mdio_t}), 64'b0000011);
    chk("midrst_rdata", 64'(rsp_rdata), 64'd0);
    last_rdata = '0;
    boot_check(1'b0);

    run_cmd(1'b1, 5'($urandom), 5'($urandom), 16'h0000, 1'b1, 16'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- Clause-22 MDIO management master plus PHY reset sequencer; drives eth_mdc, eth_mdio_o and eth_mdio_t, and reads eth_mdio_i, toward the board IOBUF and the SGMII PHY.
- Sits between the gig_eth_pcs_pma wrapper's management pins and the control logic, which issues register read/write commands over a valid/ready handshake.
- Owns eth_reset_n: holds the PHY in reset after system reset, then waits for the PHY to settle before accepting commands.

Parameters:
- CLK_DIV, 50: clock cycles per MDC half-period; MDC period = 2*CLK_DIV; legal range >= 2. The default gives 2 MHz MDC at 200 MHz.
- PHY_RST_CYCLES, 2000000: cycles eth_reset_n is held low after reset release.
- PHY_WAIT_CYCLES, 1000000: cycles after eth_reset_n rises before cmd_ready first asserts.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high when a command can be accepted
- cmd_read  in  1  1 = read, 0 = write
- cmd_phy_addr  in  5  PHY address
- cmd_reg_addr  in  5  register address
- cmd_wdata  in  16  write data (ignored for reads)
- rsp_valid  out  1  single-cycle completion pulse
- rsp_rdata  out  16  read data; holds until the next read completes
- rsp_error  out  1  read turnaround not acknowledged (PHY did not pull the second TA bit low); qualified by rsp_valid
- eth_mdc  out  1  management clock
- eth_mdio_o  out  1  MDIO output value
- eth_mdio_t  out  1  tristate control; 1 = released (input)
- eth_mdio_i  in  1  MDIO input value
- eth_reset_n  out  1  PHY reset, active-low

Behaviour:
- Reset values (asserted or mid-operation, async): eth_reset_n=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, eth_mdc=0, eth_mdio_o=1, eth_mdio_t=1, state=PHY_RST, all counters 0. Any in-flight frame is abandoned and gets no response.
- States:
  - PHY_RST: count PHY_RST_CYCLES, then set eth_reset_n=1 -> PHY_WAIT.
  - PHY_WAIT: count PHY_WAIT_CYCLES -> IDLE.
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch all cmd_* fields and build the 64-bit frame -> SHIFT. cmd_ready drops the cycle after accept.
  - SHIFT: serialise 64 bits MSB first -> DONE after the high phase of bit 63.
  - DONE: rsp_valid=1 for exactly one cycle -> IDLE, with cmd_ready=1 on the following cycle.
- Frame layout, bits 0..63 in transmit order:
  - 32 preamble ones.
  - ST=01.
  - OP: 01 for write, 10 for read.
  - PHYAD[4:0], REGAD[4:0].
  - TA (bits 46..47): 10 for write; released for read.
  - DATA[15:0] (bits 48..63).
- Bit timing:
  - Each bit is one MDC period: low phase of CLK_DIV cycles, then high phase of CLK_DIV cycles.
  - eth_mdio_o/eth_mdio_t update on the first cycle of the low phase; eth_mdc rises on the first cycle of the high phase.
  - eth_mdio_i is sampled on the cycle eth_mdc rises.
- Drive rules:
  - Write: eth_mdio_t=0 for bits 0..63.
  - Read: eth_mdio_t=0 for bits 0..45 and eth_mdio_t=1 from bit 46 onward.
  - Read: the bit-47 sample must be 0, else rsp_error=1. Bits 48..63 shift into rsp_rdata MSB first.
  - rsp_rdata updates on the rsp_valid cycle, for reads only.
- Outside SHIFT: eth_mdc=0, eth_mdio_t=1, eth_mdio_o=1.
- Latency: accept at cycle N -> bit 0 low phase starts at N+1 -> rsp_valid at N+1+128*CLK_DIV.
- Write responses always report rsp_error=0 and leave rsp_rdata unchanged.
- No response backpressure. Back-to-back commands are spaced by a minimum of 1 idle cycle (the DONE cycle).
- cmd_valid during PHY_RST or PHY_WAIT is ignored; no command is queued.

Decomposition:
- mdio_pkg:
  - MDIO_ST=2'b01, MDIO_OP_WRITE=2'b01, MDIO_OP_READ=2'b10
  - MDIO_TA_WRITE=2'b10
  - MDIO_FRAME_BITS=64, MDIO_PREAMBLE_BITS=32, MDIO_DATA_START=48
  - state enum mdio_state_t {PHY_RST, PHY_WAIT, IDLE, SHIFT, DONE}
- Sub-module mdio_clk_gen: CLK_DIV counter enabled only in SHIFT. Produces eth_mdc plus single-cycle fall_stb (start of low phase) and rise_stb strobes; the frame shifter consumes the strobes.

Test Plan (CLK_DIV=4, PHY_RST_CYCLES=16, PHY_WAIT_CYCLES=8):
- Reset release at cycle 0 -> eth_reset_n rises at cycle 16, cmd_ready rises at cycle 24; cmd_valid at cycle 10 produces no activity on MDC.
- Write phy 5'h07 reg 5'h00 data 16'h1140 -> MDIO stream is 32 ones then 01 01 00111 00000 10 0001000101000000; eth_mdio_t=0 throughout; 64 MDC rises; rsp_valid at accept+513 with rsp_error=0.
- Read phy 5'h07 reg 5'h02, PHY model drives TA-low and 16'h0141 -> eth_mdio_t=1 from bit 46; rsp_rdata=16'h0141, rsp_error=0.
- Read with MDIO left pulled high (no PHY) -> rsp_error=1, rsp_rdata=16'hFFFF.
- Reset asserted at bit 40 of a write -> all outputs return to reset values immediately, no rsp_valid, full PHY_RST/PHY_WAIT sequence repeats.
- Two back-to-back reads with cmd_valid held high -> second accept exactly 2 cycles after the first rsp_valid; the first rsp_rdata holds until the second rsp_valid.
